// File: rtl/player_pos_if.sv
// Player position controller bus: frame sync, motion requests in; sprite position out.
interface player_pos_if;
  localparam int unsigned POS_W = 12;

  logic             vsync_in;
  logic             enable;
  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  logic [POS_W-1:0] x_pos;
  logic [POS_W-1:0] y_pos;
  logic             moving;
  logic [1:0]       dir;

  modport master (
    output vsync_in, enable, btn_up, btn_down, btn_left, btn_right,
    input  x_pos, y_pos, moving, dir
  );

  modport slave (
    input  vsync_in, enable, btn_up, btn_down, btn_left, btn_right,
    output x_pos, y_pos, moving, dir
  );
endinterface

// File: rtl/player_pos_ctl.sv
// Frame-rate player sprite position controller.
// Samples buttons once per frame and walks the sprite one tile at a time in
// STEP-pixel increments inside a bounded playfield.
// Optional feature macro POS_WRAP_EN: an out-of-bounds request teleports the
// sprite to the opposite edge instead of being ignored.
module player_pos_ctl #(
  parameter int unsigned X_INIT = 140,
  parameter int unsigned Y_INIT = 100,
  parameter int unsigned X_MIN  = 20,
  parameter int unsigned X_MAX  = 720,
  parameter int unsigned Y_MIN  = 20,
  parameter int unsigned Y_MAX  = 520,
  parameter int unsigned TILE   = 20,
  parameter int unsigned STEP   = 4
) (
  input logic        clk,
  input logic        rst,
  player_pos_if.slave bus
);
  localparam int unsigned POS_W = 12;
  localparam int unsigned STEPS = TILE / STEP;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  localparam logic [POS_W-1:0] X_INIT_P = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] Y_INIT_P = POS_W'(Y_INIT);
  localparam logic [POS_W-1:0] STEP_P   = POS_W'(STEP);
  // Lowest position from which a full tile move towards the minimum stays in bounds
  localparam logic [POS_W-1:0] X_DEC_OK = POS_W'(X_MIN + TILE);
  localparam logic [POS_W-1:0] Y_DEC_OK = POS_W'(Y_MIN + TILE);
  // Highest position from which a full tile move towards the maximum stays in bounds
  localparam logic [POS_W-1:0] X_INC_OK = POS_W'(X_MAX - TILE);
  localparam logic [POS_W-1:0] Y_INC_OK = POS_W'(Y_MAX - TILE);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic {IDLE, MOVE} state_t;

  state_t           state;
  logic             vsync_q;
  logic [CNT_W-1:0] step_cnt;
  logic [POS_W-1:0] x_q, y_q;
  logic             moving_q;
  logic [1:0]       dir_q;

  logic             tick_c;
  logic             req_valid_c;
  logic [1:0]       req_dir_c;
  logic             req_legal_c;
  logic [1:0]       step_dir_c;
  logic [POS_W-1:0] x_step_c, y_step_c;

  assign tick_c    = bus.vsync_in & ~vsync_q;
  assign bus.x_pos  = x_q;
  assign bus.y_pos  = y_q;
  assign bus.moving = moving_q;
  assign bus.dir    = dir_q;

  // Fixed-priority request selection (up > down > left > right) and bounds check
  always_comb begin
    req_valid_c = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
    req_dir_c   = DIR_RIGHT;
    if (bus.btn_up)        req_dir_c = DIR_UP;
    else if (bus.btn_down) req_dir_c = DIR_DOWN;
    else if (bus.btn_left) req_dir_c = DIR_LEFT;
    case (req_dir_c)
      DIR_UP:   req_legal_c = (y_q >= Y_DEC_OK);
      DIR_DOWN: req_legal_c = (y_q <= Y_INC_OK);
      DIR_LEFT: req_legal_c = (x_q >= X_DEC_OK);
      default:  req_legal_c = (x_q <= X_INC_OK);
    endcase
  end

  // One STEP along the new request (IDLE) or the latched direction (MOVE)
  always_comb begin
    step_dir_c = (state == IDLE) ? req_dir_c : dir_q;
    x_step_c   = x_q;
    y_step_c   = y_q;
    case (step_dir_c)
      DIR_UP:   y_step_c = y_q - STEP_P;
      DIR_DOWN: y_step_c = y_q + STEP_P;
      DIR_LEFT: x_step_c = x_q - STEP_P;
      default:  x_step_c = x_q + STEP_P;
    endcase
  end

`ifdef POS_WRAP_EN
  logic [POS_W-1:0] x_wrap_c, y_wrap_c;

  // Opposite-edge target for a request that would leave the playfield
  always_comb begin
    x_wrap_c = x_q;
    y_wrap_c = y_q;
    case (req_dir_c)
      DIR_UP:   y_wrap_c = POS_W'(Y_MAX);
      DIR_DOWN: y_wrap_c = POS_W'(Y_MIN);
      DIR_LEFT: x_wrap_c = POS_W'(X_MAX);
      default:  x_wrap_c = POS_W'(X_MIN);
    endcase
  end
`endif

  // Frame-tick FSM; position, direction and moving flag only change on enabled ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vsync_q  <= 1'b0;
      step_cnt <= '0;
      x_q      <= X_INIT_P;
      y_q      <= Y_INIT_P;
      moving_q <= 1'b0;
      dir_q    <= DIR_UP;
    end else begin
      vsync_q <= bus.vsync_in;
      if (tick_c && bus.enable) begin
        case (state)
          IDLE: begin
            if (req_valid_c) begin
              if (req_legal_c) begin
                dir_q    <= req_dir_c;
                x_q      <= x_step_c;
                y_q      <= y_step_c;
                step_cnt <= CNT_W'(1);
                state    <= MOVE;
                moving_q <= 1'b1;
              end
`ifdef POS_WRAP_EN
              else begin
                dir_q <= req_dir_c;
                x_q   <= x_wrap_c;
                y_q   <= y_wrap_c;
              end
`endif
            end
          end
          MOVE: begin
            x_q <= x_step_c;
            y_q <= y_step_c;
            if (step_cnt == CNT_W'(STEPS - 1)) begin
              step_cnt <= '0;
              state    <= IDLE;
              moving_q <= 1'b0;
            end else begin
              step_cnt <= step_cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_player_pos_ctl.sv
// Scoreboard bench for player_pos_ctl: each frame pushes its expected outputs,
// a monitor pops and compares a few cycles after every vsync rising edge.
module tb_player_pos_ctl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  player_pos_if bus ();

  player_pos_ctl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         id;
    logic [11:0] x;
    logic [11:0] y;
    logic        mv;
    logic [1:0]  d;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   fid      = 0;
  bit   stim_done = 1'b0;

  task automatic check(input string name,
                       input logic [11:0] ax, input logic [11:0] ay, input logic am, input logic [1:0] ad,
                       input logic [11:0] ex, input logic [11:0] ey, input logic em, input logic [1:0] ed);
    checks++;
    if (ax !== ex || ay !== ey || am !== em || ad !== ed) begin
      failures++;
      $display("FAIL %s: got x=%0d y=%0d moving=%0d dir=%0d, expected x=%0d y=%0d moving=%0d dir=%0d",
               name, ax, ay, am, ad, ex, ey, em, ed);
    end
  endtask

  // One frame: apply buttons/enable, queue the expected post-tick outputs, pulse vsync
  task automatic frame(input logic u, input logic dn, input logic l, input logic r, input logic en,
                       input int ex, input int ey, input logic em, input logic [1:0] ed);
    exp_t e;
    @(negedge clk);
    bus.btn_up    = u;
    bus.btn_down  = dn;
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.enable    = en;
    fid++;
    e.id = fid; e.x = 12'(ex); e.y = 12'(ey); e.mv = em; e.d = ed;
    sb.push_back(e);
    bus.vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    bus.vsync_in = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: outputs are settled a few cycles after each frame start
  initial begin
    exp_t e;
    forever begin
      @(posedge bus.vsync_in);
      repeat (6) @(negedge clk);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got x=%0d y=%0d with empty scoreboard", bus.x_pos, bus.y_pos);
      end else begin
        e = sb.pop_front();
        check($sformatf("frame%0d", e.id), bus.x_pos, bus.y_pos, bus.moving, bus.dir,
              e.x, e.y, e.mv, e.d);
      end
    end
  end

  initial begin
    int x, y;
    rst           = 1'b1;
    bus.vsync_in  = 1'b0;
    bus.enable    = 1'b1;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", bus.x_pos, bus.y_pos, bus.moving, bus.dir, 12'd140, 12'd100, 1'b0, 2'd0);
    rst = 1'b0;

    // Idle frames
    for (int i = 0; i < 3; i++) frame(0, 0, 0, 0, 1, 140, 100, 0, 0);

    // Right for one frame, then released: full tile still traversed
    frame(0, 0, 0, 1, 1, 144, 100, 1, 3);
    frame(0, 0, 0, 0, 1, 148, 100, 1, 3);
    frame(0, 0, 0, 0, 1, 152, 100, 1, 3);
    frame(0, 0, 0, 0, 1, 156, 100, 1, 3);
    frame(0, 0, 0, 0, 1, 160, 100, 0, 3);
    frame(0, 0, 0, 0, 1, 160, 100, 0, 3);

    // Up + left together: up wins
    do_reset();
    frame(1, 0, 1, 0, 1, 140, 96, 1, 0);
    frame(1, 0, 1, 0, 1, 140, 92, 1, 0);
    frame(1, 0, 1, 0, 1, 140, 88, 1, 0);
    frame(1, 0, 1, 0, 1, 140, 84, 1, 0);
    frame(0, 0, 0, 0, 1, 140, 80, 0, 0);

    // Walk to the top-left corner: up 4 tiles, then left 6 tiles
    do_reset();
    for (int t = 0; t < 4; t++)
      for (int s = 1; s <= 5; s++) begin
        y = 100 - 20 * t - 4 * s;
        frame(1, 0, 0, 0, 1, 140, y, (s != 5), 0);
      end
    for (int t = 0; t < 6; t++)
      for (int s = 1; s <= 5; s++) begin
        x = 140 - 20 * t - 4 * s;
        frame(0, 0, 1, 0, 1, x, 20, (s != 5), 2);
      end
`ifdef POS_WRAP_EN
    frame(1, 0, 0, 0, 1, 20, 520, 0, 0);
    frame(0, 0, 1, 0, 1, 720, 520, 0, 2);
    frame(0, 0, 0, 0, 1, 720, 520, 0, 2);
`else
    frame(1, 0, 0, 0, 1, 20, 20, 0, 2);
    frame(0, 0, 1, 0, 1, 20, 20, 0, 2);
    frame(0, 0, 0, 0, 1, 20, 20, 0, 2);
`endif

    // Enable low mid-move pauses the tile traversal
    do_reset();
    frame(0, 0, 0, 1, 1, 144, 100, 1, 3);
    frame(0, 0, 0, 0, 1, 148, 100, 1, 3);
    for (int i = 0; i < 3; i++) frame(1, 0, 0, 0, 0, 148, 100, 1, 3);
    frame(0, 0, 0, 0, 1, 152, 100, 1, 3);
    frame(0, 0, 0, 0, 1, 156, 100, 1, 3);
    frame(0, 0, 0, 0, 1, 160, 100, 0, 3);
    frame(1, 0, 0, 0, 0, 160, 100, 0, 3);

    // Asynchronous reset between clock edges mid-move
    do_reset();
    frame(0, 0, 0, 1, 1, 144, 100, 1, 3);
    frame(0, 0, 0, 0, 1, 148, 100, 1, 3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", bus.x_pos, bus.y_pos, bus.moving, bus.dir, 12'd140, 12'd100, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    frame(0, 1, 0, 0, 1, 140, 104, 1, 1);
    frame(0, 0, 0, 0, 1, 140, 108, 1, 1);
    frame(0, 0, 0, 0, 1, 140, 112, 1, 1);
    frame(0, 0, 0, 0, 1, 140, 116, 1, 1);
    frame(0, 0, 0, 0, 1, 140, 120, 0, 1);

    repeat (20) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    stim_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    if (!stim_done) begin
      $display("FAIL watchdog: got timeout, expected stimulus completion");
      $fatal(1, "watchdog expired");
    end
  end
endmodule
